// File: rtl/serial_pkg.sv
// Shared constants and FSM state type for the serial symbol assembler.
// Defaults give a 96-bit word built from 32 three-bit symbols.
package serial_pkg;
    localparam int DEF_SELECT_SIZE    = 3;
    localparam int DEF_ROM_DATA_WIDTH = 96;
    localparam int SYMBOLS            = DEF_ROM_DATA_WIDTH / DEF_SELECT_SIZE;
    localparam int CNT_W              = $clog2(SYMBOLS);

    typedef enum logic {
        ST_COLLECT,
        ST_FULL
    } state_t;
endpackage

// File: rtl/serial_data_assembler.sv
// Packs LSB-first symbols into a word presented on a valid/ready port.
// Define SERIAL_ASSEMBLER_DOUBLE_BUF_EN to overlap collection with the held word.
module serial_data_assembler
    import serial_pkg::*;
#(
    parameter int ROM_DATA_WIDTH = DEF_ROM_DATA_WIDTH,
    parameter int SELECT_SIZE    = DEF_SELECT_SIZE
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      clr_i,
    input  logic                      sym_valid_i,
    input  logic [SELECT_SIZE-1:0]    sym_data_i,
    output logic                      sym_ready_o,
    output logic                      word_valid_o,
    output logic [ROM_DATA_WIDTH-1:0] word_data_o,
    input  logic                      word_ready_i
);
    localparam int NUM_SYM = ROM_DATA_WIDTH / SELECT_SIZE;
    localparam int CW      = $clog2(NUM_SYM);

    logic [CW-1:0]             r_cnt;
    logic [ROM_DATA_WIDTH-1:0] r_shift;
    logic                      r_word_valid;
    state_t                    r_state;

    logic                      w_acc;
    logic                      w_take;
    logic                      w_last;
    logic [ROM_DATA_WIDTH-1:0] w_shift_nxt;

    assign w_take      = r_word_valid & word_ready_i;
    assign w_acc       = sym_valid_i & sym_ready_o & ~clr_i;
    assign w_last      = w_acc & (r_cnt == CW'(NUM_SYM - 1));
    assign w_shift_nxt = {sym_data_i, r_shift[ROM_DATA_WIDTH-1:SELECT_SIZE]};

    assign word_valid_o = r_word_valid;

`ifdef SERIAL_ASSEMBLER_DOUBLE_BUF_EN
    logic [ROM_DATA_WIDTH-1:0] r_word_data;

    assign sym_ready_o = (r_state == ST_COLLECT);
    assign word_data_o = r_word_data;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt        <= '0;
            r_shift      <= '0;
            r_word_valid <= 1'b0;
            r_word_data  <= '0;
            r_state      <= ST_COLLECT;
        end else begin
            if (w_take) r_word_valid <= 1'b0;
            // Abort also discards a completed word parked in the shift reg.
            if (clr_i) begin
                r_cnt   <= '0;
                r_shift <= '0;
                r_state <= ST_COLLECT;
            end else begin
                unique case (r_state)
                    ST_COLLECT: begin
                        if (w_acc) begin
                            r_shift <= w_shift_nxt;
                            r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
                            if (w_last) begin
                                if (!r_word_valid || w_take) begin
                                    r_word_data  <= w_shift_nxt;
                                    r_word_valid <= 1'b1;
                                end else begin
                                    r_state <= ST_FULL;
                                end
                            end
                        end
                    end
                    ST_FULL: begin
                        if (w_take) begin
                            r_word_data  <= r_shift;
                            r_word_valid <= 1'b1;
                            r_state      <= ST_COLLECT;
                        end
                    end
                    default: r_state <= ST_COLLECT;
                endcase
            end
        end
    end
`else
    assign sym_ready_o = ~r_word_valid & (r_state == ST_COLLECT);
    assign word_data_o = r_shift;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt        <= '0;
            r_shift      <= '0;
            r_word_valid <= 1'b0;
            r_state      <= ST_COLLECT;
        end else begin
            r_state <= ST_COLLECT;
            if (w_take) r_word_valid <= 1'b0;
            // The shift reg is the output word; keep it while one is pending.
            if (clr_i) begin
                r_cnt <= '0;
                if (!r_word_valid) r_shift <= '0;
            end else if (w_acc) begin
                r_shift <= w_shift_nxt;
                r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
                if (w_last) r_word_valid <= 1'b1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_serial_data_assembler.sv
// Randomised bench for serial_data_assembler against a queue-based model.
// Model capacity follows SERIAL_ASSEMBLER_DOUBLE_BUF_EN (2 words, else 1).
module tb_serial_data_assembler;
    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        clr_i;
    logic        sym_valid_i;
    logic [2:0]  sym_data_i;
    logic        sym_ready_o;
    logic        word_valid_o;
    logic [95:0] word_data_o;
    logic        word_ready_i;

`ifdef SERIAL_ASSEMBLER_DOUBLE_BUF_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    bit [2:0]  part_q[$];
    bit [95:0] word_q[$];

    always #5 clk_i = ~clk_i;

    serial_data_assembler dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clr_i        (clr_i),
        .sym_valid_i  (sym_valid_i),
        .sym_data_i   (sym_data_i),
        .sym_ready_o  (sym_ready_o),
        .word_valid_o (word_valid_o),
        .word_data_o  (word_data_o),
        .word_ready_i (word_ready_i)
    );

    task automatic check(input string tag, input logic [95:0] obs,
                         input logic [95:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_ready();
        return word_q.size() < CAP;
    endfunction

    task automatic check_outputs();
        check("ready", sym_ready_o, exp_ready());
        check("valid", word_valid_o, word_q.size() > 0);
        if (word_q.size() > 0) check("data", word_data_o, word_q[0]);
    endtask

    task automatic cycle(input bit v, input bit [2:0] d, input bit wr,
                         input bit clr, output bit acc, output bit take);
        bit [95:0] w;
        sym_valid_i  = v;
        sym_data_i   = d;
        word_ready_i = wr;
        clr_i        = clr;
        acc  = v && exp_ready() && !clr;
        take = (word_q.size() > 0) && wr;
        @(posedge clk_i);
        if (clr) begin
            part_q.delete();
            if (word_q.size() > 1) void'(word_q.pop_back());
        end
        if (take) void'(word_q.pop_front());
        if (acc) begin
            part_q.push_back(d);
            if (part_q.size() == 32) begin
                w = '0;
                foreach (part_q[k]) w |= 96'(part_q[k]) << (3 * k);
                word_q.push_back(w);
                part_q.delete();
            end
        end
        @(negedge clk_i);
        check_outputs();
    endtask

    task automatic async_reset(input string tag);
        #2 rst_ni = 1'b0;
        #1;
        part_q.delete();
        word_q.delete();
        check({tag, "_valid"}, word_valid_o, 1'b0);
        check({tag, "_ready"}, sym_ready_o, 1'b1);
        check({tag, "_data"}, word_data_o, 96'd0);
        sym_valid_i = 1'b0;
        clr_i       = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    initial begin
        bit acc, take, have;
        bit [2:0] sym;
        int nacc, words, cyc;

        rst_ni = 1'b0;
        clr_i = 1'b0;
        sym_valid_i = 1'b0;
        sym_data_i = '0;
        word_ready_i = 1'b0;
        repeat (2) @(negedge clk_i);
        check("rst_valid", word_valid_o, 1'b0);
        check("rst_ready", sym_ready_o, 1'b1);
        check("rst_data", word_data_o, 96'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        for (int k = 0; k < 32; k++) cycle(1'b1, 3'(k % 8), 1'b1, 1'b0, acc, take);
        check("t1_valid", word_valid_o, 1'b1);
        check("t1_b0", word_data_o[2:0], 3'd0);
        check("t1_b7", word_data_o[23:21], 3'd7);
        check("t1_b8", word_data_o[26:24], 3'd0);
        cycle(1'b0, 3'd0, 1'b1, 1'b0, acc, take);
        check("t1_pulse", word_valid_o, 1'b0);

        nacc = 0;
        have = 1'b0;
        for (int k = 0; k < 70; k++) begin
            if (!have) begin
                sym  = 3'($urandom);
                have = 1'b1;
            end
            cycle(1'b1, sym, 1'b0, 1'b0, acc, take);
            if (acc) begin
                nacc++;
                have = 1'b0;
            end
        end
        check("t2_accepted", nacc, CAP * 32);
        for (int k = 0; k < 4; k++) cycle(1'b0, 3'd0, 1'b1, 1'b0, acc, take);

        for (int k = 0; k < 10; k++) cycle(1'b1, 3'($urandom), 1'b1, 1'b0, acc, take);
        cycle(1'b1, 3'b101, 1'b1, 1'b1, acc, take);
        for (int k = 0; k < 32; k++) cycle(1'b1, 3'b111, 1'b0, 1'b0, acc, take);
        check("t3_valid", word_valid_o, 1'b1);
        check("t3_ones", word_data_o, {96{1'b1}});
        cycle(1'b0, 3'd0, 1'b1, 1'b0, acc, take);

        for (int k = 0; k < 5; k++) cycle(1'b1, 3'($urandom), 1'b0, 1'b0, acc, take);
        async_reset("t4_mid");
        for (int k = 0; k < 40; k++) cycle(1'b1, 3'($urandom), 1'b0, 1'b0, acc, take);
        async_reset("t4_hold");
        @(negedge clk_i);
        check_outputs();

        words = 0;
        have = 1'b0;
        cyc = 0;
        while (words < 1000 && cyc < 80000) begin
            if (!have && ($urandom % 4 != 0)) begin
                sym  = 3'($urandom);
                have = 1'b1;
            end
            cycle(have, sym, 1'($urandom), 1'b0, acc, take);
            if (acc) have = 1'b0;
            if (take) words++;
            cyc++;
        end
        check("t5_words", words, 1000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
